// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV64I decode constants for alu_opgen: opcodes, op_ir
//               field positions, FIFO entry layout and FIFO state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int XLEN_C = 64;

  // Major opcodes handled by the decoder
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  // op_ir = {funct7[5], funct3, opcode}
  localparam int OPIR_W       = 11;
  localparam int OPIR_F7B     = 10;
  localparam int OPIR_F3_MSB  = 9;
  localparam int OPIR_F3_LSB  = 7;
  localparam int OPIR_OPC_MSB = 6;
  localparam int OPIR_OPC_LSB = 0;

  // Issue FIFO occupancy states
  localparam logic [1:0] FIFO_EMPTY = 2'd0;
  localparam logic [1:0] FIFO_ONE   = 2'd1;
  localparam logic [1:0] FIFO_TWO   = 2'd2;

  // One issued ALU operation
  typedef struct packed {
    logic [XLEN_C-1:0] a;
    logic [XLEN_C-1:0] b;
    logic [OPIR_W-1:0] op_ir;
    logic [4:0]        rd;
    logic              rd_we;
    logic              ill;
  } entry_t;

  // Assemble the ALU op bundle from its fields
  function automatic logic [OPIR_W-1:0] pack_op_ir(input logic f7b,
                                                   input logic [2:0] f3,
                                                   input logic [6:0] opc);
    logic [OPIR_W-1:0] r;
    r = '0;
    r[OPIR_F7B]                   = f7b;
    r[OPIR_F3_MSB:OPIR_F3_LSB]    = f3;
    r[OPIR_OPC_MSB:OPIR_OPC_LSB]  = opc;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/opgen_dec.sv
// ============================================================================
// Module      : opgen_dec
// Description : Combinational RV64I decode of one instruction into an ALU
//               issue entry (operands, op_ir, rd, rd_we, ill) plus the
//               source-register use flags for hazard detection.
//               Optional: RV_OP32_EN enables OP-32 / OP-IMM-32 decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opgen_dec
  import rv_pkg::*;
(
  input  logic [31:0]       ins,
  input  logic [XLEN_C-1:0] pc,
  input  logic [XLEN_C-1:0] rs1_val,
  input  logic [XLEN_C-1:0] rs2_val,
  output entry_t            ent,
  output logic              use_rs1,
  output logic              use_rs2
);

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [XLEN_C-1:0] imm_i;
  logic [XLEN_C-1:0] imm_u;
  logic [XLEN_C-1:0] shamt6;
  logic              is_shift;
  logic              shift_ok;
  logic              legal;

  assign opc      = ins[6:0];
  assign f3       = ins[14:12];
  assign imm_i    = {{52{ins[31]}}, ins[31:20]};
  assign imm_u    = {{32{ins[31]}}, ins[31:12], 12'b0};
  assign shamt6   = {58'b0, ins[25:20]};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Shift encodings only allow a zero or SRA-flavoured upper funct field
  assign shift_ok = (f3 == 3'b001) ? (ins[31:26] == 6'b000000) :
                    (f3 == 3'b101) ? ((ins[31:26] == 6'b000000) ||
                                      (ins[31:26] == 6'b010000)) :
                    1'b1;

`ifdef RV_OP32_EN
  logic [XLEN_C-1:0] shamt5;
  assign shamt5 = {59'b0, ins[24:20]};
`endif

  // Decode opcode into operands and op bundle; illegal leaves zero operands
  always_comb begin
    legal     = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    ent.a     = '0;
    ent.b     = '0;
    ent.op_ir = pack_op_ir(1'b0, 3'b000, opc);
    case (opc)
      OPC_OP: begin
        legal     = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        ent.a     = rs1_val;
        ent.b     = rs2_val;
        ent.op_ir = pack_op_ir(ins[30], f3, opc);
      end
      OPC_OP_IMM: begin
        if (shift_ok) begin
          legal     = 1'b1;
          use_rs1   = 1'b1;
          ent.a     = rs1_val;
          ent.b     = is_shift ? shamt6 : imm_i;
          ent.op_ir = pack_op_ir((f3 == 3'b101) && ins[30], f3, opc);
        end
      end
      OPC_LUI: begin
        legal     = 1'b1;
        ent.b     = imm_u;
      end
      OPC_AUIPC: begin
        legal     = 1'b1;
        ent.a     = pc;
        ent.b     = imm_u;
        ent.op_ir = pack_op_ir(1'b0, 3'b000, OPC_AUIPC);
      end
`ifdef RV_OP32_EN
      OPC_OP_32: begin
        legal     = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        ent.a     = rs1_val;
        ent.b     = rs2_val;
        ent.op_ir = pack_op_ir(ins[30], f3, opc);
      end
      OPC_OP_IMM_32: begin
        // Word shifts take a 5-bit shamt; bit 25 must be clear
        if (shift_ok && !(is_shift && ins[25])) begin
          legal     = 1'b1;
          use_rs1   = 1'b1;
          ent.a     = rs1_val;
          ent.b     = is_shift ? shamt5 : imm_i;
          ent.op_ir = pack_op_ir((f3 == 3'b101) && ins[30], f3, opc);
        end
      end
`endif
      default: begin
        legal = 1'b0;
      end
    endcase
    ent.rd    = ins[11:7];
    ent.rd_we = legal && (ins[11:7] != 5'd0);
    ent.ill   = !legal;
  end

endmodule

`default_nettype wire

// File: rtl/alu_opgen.sv
// ============================================================================
// Module      : alu_opgen
// Description : RV64I decode-and-issue stage. Reads the register file with
//               write-back forwarding, stalls on RAW hazards via a busy-bit
//               scoreboard, and buffers issued ops in a 2-entry FIFO with a
//               valid/ready handshake toward the ALU.
//               Optional: RV_OP32_EN enables OP-32 / OP-IMM-32 decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_opgen
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ins_vld,
  output logic            ins_rdy,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_vld,
  input  logic            ex_rdy,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [10:0]     op_ir,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            ill
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  entry_t          dec_ent;
  logic            use_rs1;
  logic            use_rs2;
  logic [31:0]     busy;
  logic [31:0]     busy_nxt;
  logic [31:0]     set_vec;
  logic [31:0]     clr_vec;
  logic            hazard;
  logic            full;
  logic            accept;
  logic            pop;
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            head;
  logic            tail;
  entry_t          mem [2];

  assign rs1_addr = ins[19:15];
  assign rs2_addr = ins[24:20];

  // A same-cycle write-back supersedes the stale register-file read
  assign rs1_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
  assign rs2_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) ? wb_data : rs2_data;

  opgen_dec u_dec (
    .ins     (ins),
    .pc      (pc),
    .rs1_val (rs1_fwd),
    .rs2_val (rs2_fwd),
    .ent     (dec_ent),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  // A source that is busy stalls unless its write-back lands this cycle
  assign hazard = (use_rs1 && busy[rs1_addr] && !(wb_we && (wb_rd == rs1_addr))) ||
                  (use_rs2 && busy[rs2_addr] && !(wb_we && (wb_rd == rs2_addr)));

  assign ins_rdy = !full && !hazard && !flush;
  assign accept  = ins_vld && ins_rdy;
  assign pop     = ex_vld && ex_rdy;

  // Scoreboard update: clear on write-back, then set on issue so set wins
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && dec_ent.rd_we) begin
      set_vec[dec_ent.rd] = 1'b1;
    end
    if (wb_we) begin
      clr_vec[wb_rd] = 1'b1;
    end
    busy_nxt    = (busy & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; flush forgets every outstanding destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // FIFO occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIFO_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO occupancy next-state; flush overrides accept and pop
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FIFO_EMPTY;
    end else begin
      case (state)
        FIFO_EMPTY: if (accept) state_nxt = FIFO_ONE;
        FIFO_ONE: begin
          if (accept && !pop) begin
            state_nxt = FIFO_TWO;
          end else if (pop && !accept) begin
            state_nxt = FIFO_EMPTY;
          end
        end
        FIFO_TWO:   if (pop) state_nxt = FIFO_ONE;
        default:    state_nxt = FIFO_EMPTY;
      endcase
    end
  end

  // FIFO status outputs decoded from the occupancy state
  always_comb begin
    ex_vld = (state != FIFO_EMPTY);
    full   = (state == FIFO_TWO);
  end

  // Entry storage and 1-bit wrapping head/tail pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= 1'b0;
      tail <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      if (accept) begin
        mem[tail] <= dec_ent;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

  assign a     = mem[head].a;
  assign b     = mem[head].b;
  assign op_ir = mem[head].op_ir;
  assign rd    = mem[head].rd;
  assign rd_we = mem[head].rd_we;
  assign ill   = mem[head].ill;

endmodule

`default_nettype wire

// File: tb/tb_alu_opgen.sv
// ============================================================================
// Module      : tb_alu_opgen
// Description : Scoreboard bench for alu_opgen. Directed scenarios followed by
//               randomized traffic; expected entries come from a reference
//               decoder and a register/pending-set model.
//               Optional: RV_OP32_EN must match the RTL build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_opgen;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [10:0] op_ir;
    logic [4:0]  rd;
    logic        rd_we;
    logic        ill;
    logic        u1;
    logic        u2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ins_vld = 1'b0;
  logic        ins_rdy;
  logic [31:0] ins = '0;
  logic [63:0] pc = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic        ex_vld;
  logic        ex_rdy = 1'b0;
  logic [63:0] a, b;
  logic [10:0] op_ir;
  logic [4:0]  rd;
  logic        rd_we, ill;

  logic [63:0] regs [32];
  bit          pend [32];
  exp_t        q [$];
  int          vectors = 0;
  int          miscompares = 0;

  // effects of the last driven cycle, applied at the next negedge
  bit          c_acc, c_flush, c_wb;
  logic [4:0]  c_wbrd;
  logic [63:0] c_wbdata;
  exp_t        c_ent;

  assign rs1_data = (rs1_addr == 5'd0) ? 64'd0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 64'd0 : regs[rs2_addr];

  always #5 clk = ~clk;

  alu_opgen #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ins_vld(ins_vld), .ins_rdy(ins_rdy),
    .ins(ins), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_vld(ex_vld), .ex_rdy(ex_rdy), .a(a), .b(b),
    .op_ir(op_ir), .rd(rd), .rd_we(rd_we), .ill(ill)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules
  function automatic exp_t ref_dec(input logic [31:0] w, input logic [63:0] pcv,
                                   input logic [63:0] r1, input logic [63:0] r2);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [5:0] top6;
    logic [63:0] immi, immu;
    bit ok, shift;
    opc   = w[6:0];
    f3    = w[14:12];
    top6  = w[31:26];
    immi  = 64'($signed(w[31:20]));
    immu  = 64'($signed({w[31:12], 12'h000}));
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    ok    = !((f3 == 3'd1 && top6 != 6'd0) || (f3 == 3'd5 && top6 != 6'd0 && top6 != 6'h10));
    e = '0;
    e.op_ir = {4'b0000, opc};
    case (opc)
      7'h33: begin e.a = r1; e.b = r2; e.op_ir = {w[30], f3, opc}; e.u1 = 1; e.u2 = 1; end
      7'h13: begin
        if (ok) begin
          e.a = r1; e.b = shift ? 64'(w[25:20]) : immi;
          e.op_ir = {(f3 == 3'd5) ? w[30] : 1'b0, f3, opc}; e.u1 = 1;
        end else e.ill = 1;
      end
      7'h37: begin e.b = immu; end
      7'h17: begin e.a = pcv; e.b = immu; end
`ifdef RV_OP32_EN
      7'h3B: begin e.a = r1; e.b = r2; e.op_ir = {w[30], f3, opc}; e.u1 = 1; e.u2 = 1; end
      7'h1B: begin
        if (ok && !(shift && w[25])) begin
          e.a = r1; e.b = shift ? 64'(w[24:20]) : immi;
          e.op_ir = {(f3 == 3'd5) ? w[30] : 1'b0, f3, opc}; e.u1 = 1;
        end else e.ill = 1;
      end
`endif
      default: e.ill = 1;
    endcase
    e.rd    = w[11:7];
    e.rd_we = !e.ill && (w[11:7] != 5'd0);
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    c_acc = 0; c_flush = 0; c_wb = 0;
  endtask

  // Apply the previous cycle's effects to the model
  task automatic commit();
    if (c_wb && c_wbrd != 5'd0) regs[c_wbrd] = c_wbdata;
    if (c_flush) begin
      q.delete();
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end else begin
      if (c_wb) pend[c_wbrd] = 0;
      if (c_acc) begin
        q.push_back(c_ent);
        if (c_ent.rd_we) pend[c_ent.rd] = 1;
      end
    end
    c_acc = 0; c_flush = 0; c_wb = 0;
  endtask

  // Drive one cycle, predict ins_rdy and record what the edge will do
  task automatic cycle(input bit vld, input logic [31:0] w, input logic [63:0] p,
                       input bit we, input logic [4:0] wrd, input logic [63:0] wd,
                       input bit er, input bit fl);
    logic [63:0] f1, f2;
    logic [4:0] s1, s2;
    exp_t e;
    bit haz, rdy;
    @(negedge clk);
    commit();
    ins_vld = vld; ins = w; pc = p; wb_we = we; wb_rd = wrd; wb_data = wd;
    ex_rdy = er; flush = fl;
    #1;
    s1 = w[19:15]; s2 = w[24:20];
    f1 = (we && wrd != 0 && wrd == s1) ? wd : ((s1 == 0) ? 64'd0 : regs[s1]);
    f2 = (we && wrd != 0 && wrd == s2) ? wd : ((s2 == 0) ? 64'd0 : regs[s2]);
    e = ref_dec(w, p, f1, f2);
    haz = (e.u1 && pend[s1] && !(we && wrd == s1)) || (e.u2 && pend[s2] && !(we && wrd == s2));
    rdy = (q.size() < 2) && !haz && !fl;
    chk("ins_rdy", {63'd0, ins_rdy}, {63'd0, rdy});
    chk("rs_addr", {54'd0, rs1_addr, rs2_addr}, {54'd0, s1, s2});
    c_acc = vld && rdy; c_ent = e; c_flush = fl;
    c_wb = we; c_wbrd = wrd; c_wbdata = wd;
  endtask

  task automatic idle(input bit er);
    cycle(0, 32'h0, 64'h0, 0, 5'd0, 64'h0, er, 0);
  endtask

  // Monitor: compare the FIFO head with the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !flush) begin
        chk("ex_vld", {63'd0, ex_vld}, {63'd0, q.size() > 0});
        if (ex_vld && q.size() > 0) begin
          chk("a", a, q[0].a);
          chk("b", b, q[0].b);
          chk("op_ir", {53'd0, op_ir}, {53'd0, q[0].op_ir});
          chk("rd", {59'd0, rd}, {59'd0, q[0].rd});
          chk("rd_we", {63'd0, rd_we}, {63'd0, q[0].rd_we});
          chk("ill", {63'd0, ill}, {63'd0, q[0].ill});
          if (ex_rdy) void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    logic [6:0] opcs [8];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h3B, 7'h1B, 7'h13, 7'h33};
    w = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 9) != 0) begin
      w[6:0] = opcs[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) != 0) w[31:26] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00;
      if ($urandom_range(0, 3) != 0) w[25] = 1'b0;
    end
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst ex_vld", {63'd0, ex_vld}, 64'd0);
    chk("rst a", a, 64'd0);
    chk("rst b", b, 64'd0);
    chk("rst op_ir", {53'd0, op_ir}, 64'd0);
    chk("rst rd", {59'd0, rd, rd_we, ill}, 64'd0);
    chk("rst ins_rdy", {63'd0, ins_rdy}, 64'd1);

    // srai, slti x0, addi with constant expectations
    cycle(1, 32'h4030D113, 64'h1000, 0, 0, 0, 1, 0);
    cycle(1, 32'h0000A013, 64'h1004, 0, 0, 0, 1, 0);
    chk("srai op_ir", {53'd0, op_ir}, 64'h693);
    chk("srai b", b, 64'd3);
    cycle(1, 32'h00500093, 64'h1008, 0, 0, 0, 1, 0);
    chk("slti rd_we/ill", {62'd0, rd_we, ill}, 64'd0);
    chk("slti op_ir", {53'd0, op_ir}, 64'h113);
    cycle(0, 32'h0, 64'h0, 0, 0, 0, 1, 0);
    chk("addi a", a, 64'd0);
    chk("addi b", b, 64'd5);
    chk("addi op_ir", {53'd0, op_ir}, 64'h013);
    chk("addi rd", {58'd0, rd, rd_we}, {58'd0, 5'd1, 1'b1});

    // RAW stall on x1 until write-back supplies 7
    cycle(1, 32'h001081B3, 64'h100C, 0, 0, 0, 1, 0);
    chk("hazard stall", {63'd0, ins_rdy}, 64'd0);
    cycle(1, 32'h001081B3, 64'h100C, 1, 5'd1, 64'd7, 1, 0);
    chk("hazard release", {63'd0, ins_rdy}, 64'd1);
    idle(1);
    chk("fwd a", a, 64'd7);
    chk("fwd b", b, 64'd7);

    // FIFO fill, back-pressure, one pop, ordering
    cycle(1, 32'h00000013, 64'h0, 1, 5'd2, 64'd9, 1, 1);
    cycle(1, 32'h123452B7, 64'h2000, 1, 5'd3, 64'd1, 0, 0);
    cycle(1, 32'hFFFFF317, 64'h2004, 0, 0, 0, 0, 0);
    cycle(1, 32'h000013B7, 64'h2008, 0, 0, 0, 0, 0);
    chk("full stall", {63'd0, ins_rdy}, 64'd0);
    cycle(1, 32'h000013B7, 64'h2008, 0, 0, 0, 1, 0);
    chk("full stall pop", {63'd0, ins_rdy}, 64'd0);
    cycle(1, 32'h000013B7, 64'h2008, 0, 0, 0, 0, 0);
    chk("refill", {63'd0, ins_rdy}, 64'd1);

    // flush with FIFO full and x5/x6/x7 busy
    cycle(1, 32'h006284B3, 64'h3000, 0, 0, 0, 0, 1);
    chk("flush rdy", {63'd0, ins_rdy}, 64'd0);
    cycle(1, 32'h00628433, 64'h3004, 0, 0, 0, 0, 0);
    chk("post-flush ex_vld", {63'd0, ex_vld}, 64'd0);
    chk("post-flush rdy", {63'd0, ins_rdy}, 64'd1);

    // addw depends on the OP-32 option
    cycle(1, 32'h002080BB, 64'h3008, 0, 0, 0, 1, 0);
    idle(1);
`ifdef RV_OP32_EN
    chk("addw op_ir", {53'd0, op_ir}, 64'h03B);
    chk("addw a", a, regs[1]);
    chk("addw b", b, regs[2]);
`else
    chk("addw ill", {62'd0, ill, rd_we}, 64'd2);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_ins(), {$urandom, $urandom},
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    // asynchronous reset with entries buffered
    cycle(1, 32'h00100093, 64'h4000, 0, 0, 0, 0, 0);
    cycle(1, 32'h00200113, 64'h4004, 0, 0, 0, 0, 0);
    @(negedge clk);
    commit();
    ins_vld = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst ex_vld", {63'd0, ex_vld}, 64'd0);
    chk("async rst a", a, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 200; n++) begin
      cycle($urandom_range(0, 1) != 0, rand_ins(), {$urandom, $urandom},
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, 0);
    end
    repeat (4) idle(1);
    @(negedge clk);
    commit();
    #3;
    chk("drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
